irig_time_keeper: RTL and testbench
===================================

# irig_time_keeper

Time-of-day keeper that sits downstream of the IRIG BCD decoder and replaces the seconds-only roll-forward register in the top level. It loads day/hour/minute/second on a decoder frame, advances on each PPS, and keeps a sub-second tick count. It can free-run through missing PPS pulses. It timestamps N_CH external event inputs into per-channel capture registers with an ack/overflow handshake for the AXI-lite register block.

## Interface
- CLK_HZ, 100_000_000: clk frequency; sub-second counter range 0..CLK_HZ-1
- SUBSEC_W, 27: sub-second counter width; must satisfy 2^SUBSEC_W > CLK_HZ+PPS_TOL
- PPS_TOL, 1024: cycles of PPS lateness tolerated before declaring a missed PPS
- N_CH, 4: number of event capture channels
---
- clk  in  1  single clock for the whole block
- rst_n  in  1  reset, asynchronous assert, active-low
- bcd_valid  in  1  decoder frame valid; a rising edge loads time
- sec_i/min_i  in  6/6  decoded seconds/minutes
- hr_i  in  5  decoded hours
- day_i  in  9  decoded day, 0-based
- pps  in  1  single-cycle PPS pulse, synchronous to clk
- leap_year  in  1  1: last day is 365; 0: last day is 364
- evt  in  N_CH  asynchronous event inputs
- cap_ack  in  N_CH  single-cycle acknowledge per channel
- time_o  out  26  {day,hr,min,sec}
- subsec_o  out  SUBSEC_W  cycles since the last second boundary
- time_valid  out  1  high in LOCKED or HOLDOVER
- holdover  out  1  high in HOLDOVER
- cap_time  out  26*N_CH  captured {day,hr,min,sec}; channel k at [26k+25:26k]
- cap_subsec  out  SUBSEC_W*N_CH  captured sub-second value
- cap_valid  out  N_CH  capture pending
- cap_ovf  out  N_CH  sticky; an event was lost while cap_valid was high

## Operation
- Reset state: all outputs 0; state is UNSYNC.
- States are UNSYNC, LOCKED and HOLDOVER.
- UNSYNC:
  - time and subsec are held.
  - pps is ignored.
  - A bcd_valid rising edge loads the inputs and clears subsec, then moves to LOCKED.
- bcd_valid rising edge in any state:
  - Loads the time and clears subsec, then moves to LOCKED.
  - It wins over a simultaneous pps; that pps is discarded.
- LOCKED:
  - subsec increments by 1 each cycle.
  - pps advances the time by 1 s and sets subsec to 0.
  - If subsec reaches CLK_HZ+PPS_TOL-1 with no pps, the PPS is missed; the response is set by the build option (see Configuration).
- HOLDOVER:
  - subsec counts 0..CLK_HZ-1.
  - The wrap from CLK_HZ-1 to 0 advances the time by 1 s.
  - pps sets subsec to 0, advances the time by 1 s and moves to LOCKED.
  - A pps in the same cycle as the wrap advances the time once only.
- Advance carry chain:
  - sec 59→0 carries into min.
  - min 59→0 carries into hr.
  - hr 23→0 carries into day.
  - day wraps to 0 at 364, or at 365 when leap_year=1.
- Capture, per channel:
  - 2-FF synchroniser feeds a rising-edge detect.
  - If time_valid=1 at the edge: cap_time/cap_subsec take time_o/subsec_o from that cycle, and cap_valid is set.
  - Edges are ignored while time_valid=0.
  - An edge while cap_valid=1 sets cap_ovf and does not overwrite the capture registers.
  - cap_ack clears cap_valid and cap_ovf.
  - Edge and cap_ack in the same cycle: the new capture loads, cap_valid stays 1 and cap_ovf is cleared.
- rst_n asserted mid-operation clears all state immediately, including pending captures.

## Timing
- pps → time_o/subsec_o updated: 1 cycle.
- bcd_valid rising → loaded time on time_o: 1 cycle after the edge-detect cycle, i.e. 2 cycles from input.
- evt pin edge → cap_valid high: 3 cycles (2 sync + 1 register).
- Captured value equals time_o/subsec_o in the edge-detect cycle.
- cap_ack → cap_valid low: 1 cycle.
- State change to HOLDOVER, and holdover/time_valid update: the cycle after the miss is detected.

## Configuration
- TIME_KEEPER_HOLDOVER_EN defined, on a missed PPS:
  - Advance the time by 1 s and load subsec with PPS_TOL, preserving the nominal phase.
  - Enter HOLDOVER; holdover=1.
- TIME_KEEPER_HOLDOVER_EN undefined, on a missed PPS:
  - Enter UNSYNC; time_valid=0 and time_o is frozen.
  - holdover is tied to 0 and the HOLDOVER state is not synthesised.

## Structure
- Package irig_tk_pkg holds:
  - A time-field struct typedef (day 9, hr 5, min 6, sec 6).
  - The state enum.
  - Constants SEC_LAST=59, MIN_LAST=59, HR_LAST=23, DAY_LAST=364, DAY_LAST_LEAP=365.
- Sub-module irig_tk_capture holds one channel: synchroniser, edge detect, capture registers and ack/ovf logic. It is generated N_CH times.

## Test plan
Bench parameters: CLK_HZ=1000, PPS_TOL=10, N_CH=4.
- Load 0/23:59:58 with leap_year=0, then two pps → time_o 0/23:59:59, then 1/00:00:00; subsec_o returns to 0 after each pps.
- Load 364/23:59:59 with leap_year=0 and pps → day 0; repeat with leap_year=1 → day 365, then the next rollover → day 0.
- LOCKED, no pps for 1010 cycles:
  - With the macro: holdover=1, time +1 s, subsec=10; the next time increment comes 990 cycles later.
  - Without the macro: time_valid=0 and time_o is frozen.
- evt[2] edge at subsec 500 → cap_valid[2] after 3 cycles with cap_subsec equal to subsec_o in the edge-detect cycle; a second edge before ack → cap_ovf[2]=1 and the value is unchanged; cap_ack → both cleared.
- bcd_valid rising edge in the same cycle as pps → time_o equals the decoder value with no +1 s; subsec=0.
- rst_n pulsed low while cap_valid=0xF and LOCKED → all outputs 0, state UNSYNC; evt edges ignored until the next load.

Source files
------------

// File: rtl/irig_tk_pkg.sv
// Shared types, field limits and the one-second carry helper for the IRIG time keeper.
package irig_tk_pkg;

    typedef struct packed {
        logic [8:0] day;
        logic [4:0] hr;
        logic [5:0] min;
        logic [5:0] sec;
    } tk_time_t;

    typedef enum logic [1:0] {
        ST_UNSYNC   = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_HOLDOVER = 2'd2
    } tk_state_e;

    localparam logic [5:0] SEC_LAST      = 6'd59;
    localparam logic [5:0] MIN_LAST      = 6'd59;
    localparam logic [4:0] HR_LAST       = 5'd23;
    localparam logic [8:0] DAY_LAST      = 9'd364;
    localparam logic [8:0] DAY_LAST_LEAP = 9'd365;

    function automatic tk_time_t tk_advance(input tk_time_t t, input logic leap);
        tk_time_t   n;
        logic [8:0] last;
        n    = t;
        last = leap ? DAY_LAST_LEAP : DAY_LAST;
        if (t.sec >= SEC_LAST) begin
            n.sec = '0;
            if (t.min >= MIN_LAST) begin
                n.min = '0;
                if (t.hr >= HR_LAST) begin
                    n.hr  = '0;
                    n.day = (t.day >= last) ? '0 : t.day + 9'd1;
                end else begin
                    n.hr = t.hr + 5'd1;
                end
            end else begin
                n.min = t.min + 6'd1;
            end
        end else begin
            n.sec = t.sec + 6'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/irig_tk_capture.sv
// One event-timestamp channel: 2-FF synchroniser, rising-edge detect, capture
// registers and ack/overflow handshake.
module irig_tk_capture
    import irig_tk_pkg::*;
#(
    parameter int SUBSEC_W = 27
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                evt_i,
    input  logic                ack_i,
    input  logic                time_valid_i,
    input  tk_time_t            time_i,
    input  logic [SUBSEC_W-1:0] subsec_i,
    output tk_time_t            cap_time_o,
    output logic [SUBSEC_W-1:0] cap_subsec_o,
    output logic                cap_valid_o,
    output logic                cap_ovf_o
);

    logic [2:0]          sync_q;
    logic                evt_rise;
    tk_time_t            cap_time_q, cap_time_d;
    logic [SUBSEC_W-1:0] cap_subsec_q, cap_subsec_d;
    logic                cap_valid_q, cap_valid_d;
    logic                cap_ovf_q, cap_ovf_d;

    assign evt_rise = sync_q[1] & ~sync_q[2];

    always_comb begin
        cap_time_d   = cap_time_q;
        cap_subsec_d = cap_subsec_q;
        cap_valid_d  = cap_valid_q;
        cap_ovf_d    = cap_ovf_q;
        if (ack_i) begin
            cap_valid_d = 1'b0;
            cap_ovf_d   = 1'b0;
        end
        // An ack in the same cycle frees the slot, so the new edge loads instead of overflowing.
        if (evt_rise && time_valid_i) begin
            if (cap_valid_q && !ack_i) begin
                cap_ovf_d = 1'b1;
            end else begin
                cap_time_d   = time_i;
                cap_subsec_d = subsec_i;
                cap_valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            cap_time_q   <= '0;
            cap_subsec_q <= '0;
            cap_valid_q  <= 1'b0;
            cap_ovf_q    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[1:0], evt_i};
            cap_time_q   <= cap_time_d;
            cap_subsec_q <= cap_subsec_d;
            cap_valid_q  <= cap_valid_d;
            cap_ovf_q    <= cap_ovf_d;
        end
    end

    assign cap_time_o   = cap_time_q;
    assign cap_subsec_o = cap_subsec_q;
    assign cap_valid_o  = cap_valid_q;
    assign cap_ovf_o    = cap_ovf_q;

endmodule

// File: rtl/irig_time_keeper.sv
// IRIG time-of-day keeper with PPS advance, sub-second count and N_CH event capture.
// Define TIME_KEEPER_HOLDOVER_EN to free-run through missed PPS instead of dropping to UNSYNC.
module irig_time_keeper
    import irig_tk_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SUBSEC_W = 27,
    parameter int PPS_TOL  = 1024,
    parameter int N_CH     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bcd_valid,
    input  logic [5:0]                 sec_i,
    input  logic [5:0]                 min_i,
    input  logic [4:0]                 hr_i,
    input  logic [8:0]                 day_i,
    input  logic                       pps,
    input  logic                       leap_year,
    input  logic [N_CH-1:0]            evt,
    input  logic [N_CH-1:0]            cap_ack,
    output logic [25:0]                time_o,
    output logic [SUBSEC_W-1:0]        subsec_o,
    output logic                       time_valid,
    output logic                       holdover,
    output logic [26*N_CH-1:0]         cap_time,
    output logic [SUBSEC_W*N_CH-1:0]   cap_subsec,
    output logic [N_CH-1:0]            cap_valid,
    output logic [N_CH-1:0]            cap_ovf
);

    localparam logic [SUBSEC_W-1:0] MISS_AT = SUBSEC_W'(CLK_HZ + PPS_TOL - 1);
`ifdef TIME_KEEPER_HOLDOVER_EN
    localparam logic [SUBSEC_W-1:0] WRAP_AT = SUBSEC_W'(CLK_HZ - 1);
    localparam logic [SUBSEC_W-1:0] TOL_LD  = SUBSEC_W'(PPS_TOL);
`endif

    tk_state_e           state_q, state_d;
    tk_time_t            time_q, time_d, time_adv;
    logic [SUBSEC_W-1:0] subsec_q, subsec_d;
    logic                bcd_q, bcd_qq, bcd_rise;

    assign bcd_rise = bcd_q & ~bcd_qq;
    assign time_adv = tk_advance(time_q, leap_year);

    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        subsec_d = subsec_q;
        if (bcd_rise) begin
            time_d   = '{day: day_i, hr: hr_i, min: min_i, sec: sec_i};
            subsec_d = '0;
            state_d  = ST_LOCKED;
        end else begin
            case (state_q)
                ST_LOCKED: begin
                    if (pps) begin
                        time_d   = time_adv;
                        subsec_d = '0;
                    end else if (subsec_q == MISS_AT) begin
`ifdef TIME_KEEPER_HOLDOVER_EN
                        // Restart at PPS_TOL so the free-running second keeps the nominal PPS phase.
                        time_d   = time_adv;
                        subsec_d = TOL_LD;
                        state_d  = ST_HOLDOVER;
`else
                        state_d  = ST_UNSYNC;
`endif
                    end else begin
                        subsec_d = subsec_q + SUBSEC_W'(1);
                    end
                end
`ifdef TIME_KEEPER_HOLDOVER_EN
                ST_HOLDOVER: begin
                    if (pps) begin
                        time_d   = time_adv;
                        subsec_d = '0;
                        state_d  = ST_LOCKED;
                    end else if (subsec_q >= WRAP_AT) begin
                        time_d   = time_adv;
                        subsec_d = '0;
                    end else begin
                        subsec_d = subsec_q + SUBSEC_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_UNSYNC;
            time_q   <= '0;
            subsec_q <= '0;
            bcd_q    <= 1'b0;
            bcd_qq   <= 1'b0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            subsec_q <= subsec_d;
            bcd_q    <= bcd_valid;
            bcd_qq   <= bcd_q;
        end
    end

    assign time_o     = time_q;
    assign subsec_o   = subsec_q;
    assign time_valid = (state_q != ST_UNSYNC);
`ifdef TIME_KEEPER_HOLDOVER_EN
    assign holdover   = (state_q == ST_HOLDOVER);
`else
    assign holdover   = 1'b0;
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_cap
        irig_tk_capture #(
            .SUBSEC_W(SUBSEC_W)
        ) u_cap (
            .clk          (clk),
            .rst_n        (rst_n),
            .evt_i        (evt[k]),
            .ack_i        (cap_ack[k]),
            .time_valid_i (time_valid),
            .time_i       (time_q),
            .subsec_i     (subsec_q),
            .cap_time_o   (cap_time[26*k +: 26]),
            .cap_subsec_o (cap_subsec[SUBSEC_W*k +: SUBSEC_W]),
            .cap_valid_o  (cap_valid[k]),
            .cap_ovf_o    (cap_ovf[k])
        );
    end

endmodule

// File: tb/tb_irig_time_keeper.sv
// Directed bench for irig_time_keeper; builds with or without TIME_KEEPER_HOLDOVER_EN.
module tb_irig_time_keeper;

    localparam int CLK_HZ  = 1000;
    localparam int PPS_TOL = 10;
    localparam int N_CH    = 4;
    localparam int SW      = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              bcd_valid = 1'b0;
    logic              pps = 1'b0;
    logic              leap_year = 1'b0;
    logic [5:0]        sec_i = '0;
    logic [5:0]        min_i = '0;
    logic [4:0]        hr_i = '0;
    logic [8:0]        day_i = '0;
    logic [N_CH-1:0]   evt = '0;
    logic [N_CH-1:0]   cap_ack = '0;
    logic [25:0]       time_o;
    logic [SW-1:0]     subsec_o;
    logic              time_valid;
    logic              holdover;
    logic [26*N_CH-1:0] cap_time;
    logic [SW*N_CH-1:0] cap_subsec;
    logic [N_CH-1:0]   cap_valid;
    logic [N_CH-1:0]   cap_ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    irig_time_keeper #(
        .CLK_HZ   (CLK_HZ),
        .SUBSEC_W (SW),
        .PPS_TOL  (PPS_TOL),
        .N_CH     (N_CH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_valid  (bcd_valid),
        .sec_i      (sec_i),
        .min_i      (min_i),
        .hr_i       (hr_i),
        .day_i      (day_i),
        .pps        (pps),
        .leap_year  (leap_year),
        .evt        (evt),
        .cap_ack    (cap_ack),
        .time_o     (time_o),
        .subsec_o   (subsec_o),
        .time_valid (time_valid),
        .holdover   (holdover),
        .cap_time   (cap_time),
        .cap_subsec (cap_subsec),
        .cap_valid  (cap_valid),
        .cap_ovf    (cap_ovf)
    );

    function automatic logic [25:0] tv(input int d, input int h, input int m, input int s);
        return {9'(d), 5'(h), 6'(m), 6'(s)};
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int d, input int h, input int m, input int s, input logic leap);
        bcd_valid = 1'b0;
        tick(1);
        day_i = 9'(d); hr_i = 5'(h); min_i = 6'(m); sec_i = 6'(s);
        leap_year = leap;
        bcd_valid = 1'b1;
        tick(2);
        bcd_valid = 1'b0;
    endtask

    task automatic pulse_pps();
        pps = 1'b1;
        tick(1);
        pps = 1'b0;
    endtask

    initial begin
        tick(3);
        check("rst_time",   64'(time_o), 64'(0));
        check("rst_subsec", 64'(subsec_o), 64'(0));
        check("rst_valid",  64'(time_valid), 64'(0));
        check("rst_hold",   64'(holdover), 64'(0));
        check("rst_capv",   64'(cap_valid), 64'(0));
        rst_n = 1'b1;
        tick(1);

        // Day/hour rollover through two PPS
        do_load(0, 23, 59, 58, 1'b0);
        check("load_time",  64'(time_o), 64'(tv(0, 23, 59, 58)));
        check("load_sub",   64'(subsec_o), 64'(0));
        check("load_valid", 64'(time_valid), 64'(1));
        tick(5);
        check("sub_count",  64'(subsec_o), 64'(5));
        pulse_pps();
        check("pps1_time",  64'(time_o), 64'(tv(0, 23, 59, 59)));
        check("pps1_sub",   64'(subsec_o), 64'(0));
        tick(3);
        pulse_pps();
        check("pps2_time",  64'(time_o), 64'(tv(1, 0, 0, 0)));
        check("pps2_sub",   64'(subsec_o), 64'(0));

        // Year wrap, normal and leap
        do_load(364, 23, 59, 59, 1'b0);
        pulse_pps();
        check("yr_wrap",    64'(time_o), 64'(tv(0, 0, 0, 0)));
        do_load(364, 23, 59, 59, 1'b1);
        pulse_pps();
        check("leap_365",   64'(time_o), 64'(tv(365, 0, 0, 0)));
        do_load(365, 23, 59, 59, 1'b1);
        pulse_pps();
        check("leap_wrap",  64'(time_o), 64'(tv(0, 0, 0, 0)));

        // Event capture on channel 2 with edge-detect cycle at subsec 500
        do_load(10, 1, 2, 3, 1'b0);
        tick(498);
        evt[2] = 1'b1;
        tick(1);
        check("cap_early",  64'(cap_valid), 64'(0));
        tick(1);
        check("cap_detsub", 64'(subsec_o), 64'(500));
        tick(1);
        check("cap_valid",  64'(cap_valid), 64'(4'b0100));
        check("cap_sub",    64'(cap_subsec[2*SW +: SW]), 64'(500));
        check("cap_time",   64'(cap_time[2*26 +: 26]), 64'(tv(10, 1, 2, 3)));
        evt[2] = 1'b0;
        tick(3);
        evt[2] = 1'b1;
        tick(3);
        check("ovf_set",    64'(cap_ovf), 64'(4'b0100));
        check("ovf_valid",  64'(cap_valid), 64'(4'b0100));
        check("ovf_keep",   64'(cap_subsec[2*SW +: SW]), 64'(500));
        cap_ack[2] = 1'b1;
        tick(1);
        cap_ack[2] = 1'b0;
        check("ack_valid",  64'(cap_valid), 64'(0));
        check("ack_ovf",    64'(cap_ovf), 64'(0));
        evt = '0;

        // Missed PPS
        pulse_pps();
        check("pre_miss",   64'(time_o), 64'(tv(10, 1, 2, 4)));
        tick(1009);
        check("miss_edge_sub", 64'(subsec_o), 64'(1009));
        check("miss_edge_vld", 64'(time_valid), 64'(1));
        tick(1);
`ifdef TIME_KEEPER_HOLDOVER_EN
        check("ho_flag",    64'(holdover), 64'(1));
        check("ho_time",    64'(time_o), 64'(tv(10, 1, 2, 5)));
        check("ho_sub",     64'(subsec_o), 64'(10));
        tick(989);
        check("ho_prewrap", 64'(time_o), 64'(tv(10, 1, 2, 5)));
        check("ho_sub999",  64'(subsec_o), 64'(999));
        tick(1);
        check("ho_wrap",    64'(time_o), 64'(tv(10, 1, 2, 6)));
        check("ho_wrapsub", 64'(subsec_o), 64'(0));
        pulse_pps();
        check("relock_t",   64'(time_o), 64'(tv(10, 1, 2, 7)));
        check("relock_h",   64'(holdover), 64'(0));
        check("relock_v",   64'(time_valid), 64'(1));
`else
        check("miss_valid", 64'(time_valid), 64'(0));
        check("miss_hold",  64'(holdover), 64'(0));
        check("miss_time",  64'(time_o), 64'(tv(10, 1, 2, 4)));
        tick(20);
        pulse_pps();
        check("frozen",     64'(time_o), 64'(tv(10, 1, 2, 4)));
`endif

        // Load wins over a simultaneous PPS
        do_load(50, 5, 5, 5, 1'b0);
        tick(1);
        day_i = 9'd100; hr_i = 5'd12; min_i = 6'd30; sec_i = 6'd0;
        bcd_valid = 1'b1;
        tick(1);
        pps = 1'b1;
        tick(1);
        pps = 1'b0;
        bcd_valid = 1'b0;
        check("bcdpps_time", 64'(time_o), 64'(tv(100, 12, 30, 0)));
        check("bcdpps_sub",  64'(subsec_o), 64'(0));
        tick(1);
        check("bcdpps_next", 64'(subsec_o), 64'(1));

        // Reset with all channels pending
        tick(3);
        evt = '1;
        tick(3);
        check("all_cap",    64'(cap_valid), 64'(4'hF));
        rst_n = 1'b0;
        #2;
        check("ar_time",    64'(time_o), 64'(0));
        check("ar_sub",     64'(subsec_o), 64'(0));
        check("ar_valid",   64'(time_valid), 64'(0));
        check("ar_capv",    64'(cap_valid), 64'(0));
        check("ar_capt",    64'(cap_time), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        evt = '0;
        tick(3);
        evt = '1;
        tick(4);
        check("unsync_ign", 64'(cap_valid), 64'(0));
        check("unsync_t",   64'(time_o), 64'(0));
        do_load(1, 0, 0, 0, 1'b0);
        evt = '0;
        tick(3);
        evt[0] = 1'b1;
        tick(3);
        check("relock_cap", 64'(cap_valid), 64'(4'b0001));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
